// File: rtl/seq_comparator_pkg.sv
// seq_comparator_pkg: FSM state and result-flag encodings for seq_comparator
package seq_comparator_pkg;
  typedef enum logic {IDLE, CMP} state_t;
  localparam logic [2:0] FLAG_NONE = 3'b000;
  localparam logic [2:0] FLAG_GT   = 3'b100;
  localparam logic [2:0] FLAG_EQ   = 3'b010;
  localparam logic [2:0] FLAG_LT   = 3'b001;
endpackage

// File: rtl/seq_comparator_chunk_cmp.sv
// chunk_cmp: unsigned magnitude compare of one CHUNK-bit slice (a,b in; gt,eq,lt out)
module chunk_cmp #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  output logic             gt,
  output logic             eq,
  output logic             lt
);
  assign gt = a > b;
  assign eq = a == b;
  assign lt = a < b;
endmodule

// File: rtl/seq_comparator.sv
// seq_comparator: multi-cycle MSB-first chunked comparator with early termination
// Ports: clk, rst_n (async active-low), start, A, B, signed_mode (only with
// SEQ_CMP_SIGNED_EN), busy, done (1-cycle pulse), A_greater_B/A_equal_B/A_less_B.
import seq_comparator_pkg::*;
module seq_comparator #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
`ifdef SEQ_CMP_SIGNED_EN
  input  logic             signed_mode,
`endif
  output logic             busy,
  output logic             done,
  output logic             A_greater_B,
  output logic             A_equal_B,
  output logic             A_less_B
);
  localparam int N  = WIDTH / CHUNK;
  localparam int IW = N > 1 ? $clog2(N) : 1;
  state_t           state, state_nx;
  logic [WIDTH-1:0] a_r, b_r, msb_mask;
  logic [IW-1:0]    idx;
  logic [2:0]       flags;
  logic             gt, eq, lt, accept, decide;
`ifdef SEQ_CMP_SIGNED_EN
  // Flipping the sign bit maps two's-complement order onto unsigned order,
  // so it is folded into the operand capture.
  assign msb_mask = {signed_mode, {(WIDTH-1){1'b0}}};
`else
  assign msb_mask = '0;
`endif
  chunk_cmp #(.CHUNK(CHUNK)) u_chunk_cmp (
    .a (a_r[idx*CHUNK +: CHUNK]),
    .b (b_r[idx*CHUNK +: CHUNK]),
    .gt(gt),
    .eq(eq),
    .lt(lt)
  );
  assign accept = state == IDLE && start;
  assign decide = state == CMP && (!eq || idx == '0);
  always_comb begin
    state_nx = accept ? CMP : decide ? IDLE : state;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_r   <= '0;
      b_r   <= '0;
      idx   <= '0;
      flags <= FLAG_NONE;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      done  <= decide;
      if (accept) begin
        a_r <= A ^ msb_mask;
        b_r <= B ^ msb_mask;
        idx <= IW'(N - 1);
      end else if (decide) begin
        flags <= gt ? FLAG_GT : lt ? FLAG_LT : FLAG_EQ;
      end else if (state == CMP) begin
        idx <= idx - 1'b1;
      end
    end
  end
  assign busy = state == CMP;
  assign {A_greater_B, A_equal_B, A_less_B} = flags;
endmodule

// File: tb/tb_seq_comparator.sv
// tb_seq_comparator: directed self-checking bench for seq_comparator (WIDTH=16, CHUNK=4)
module tb_seq_comparator;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] A = '0, B = '0;
  logic        busy, done, A_greater_B, A_equal_B, A_less_B;
  logic [2:0]  flags_o, prev_f;
  int          total = 0, passed = 0;
`ifdef SEQ_CMP_SIGNED_EN
  logic        signed_mode = 1'b0;
`endif
  always #5 clk = ~clk;
  seq_comparator #(.WIDTH(16), .CHUNK(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .A          (A),
    .B          (B),
`ifdef SEQ_CMP_SIGNED_EN
    .signed_mode(signed_mode),
`endif
    .busy       (busy),
    .done       (done),
    .A_greater_B(A_greater_B),
    .A_equal_B  (A_equal_B),
    .A_less_B   (A_less_B)
  );
  assign flags_o = {A_greater_B, A_equal_B, A_less_B};
  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask
  task automatic wait_done(input string tag, input int k0, input int exp_k, input logic [2:0] exp_f);
    int k = k0;
    while (!done && k < 20) begin
      @(posedge clk); #1 k++;
    end
    check({tag, " latency"}, k, exp_k);
    check({tag, " flags"}, flags_o, exp_f);
    check({tag, " busy_low"}, busy, 0);
    prev_f = exp_f;
  endtask
  task automatic run_cmp(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input int exp_k, input logic [2:0] exp_f);
    @(negedge clk); A = a; B = b; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check({tag, " busy_e0"}, busy, 1);
    check({tag, " flags_held"}, flags_o, prev_f);
    wait_done(tag, 0, exp_k, exp_f);
    @(posedge clk); #1 check({tag, " done_pulse"}, done, 0);
  endtask
  initial begin
    int seen;
    prev_f = 3'b000;
    #2;
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst flags", flags_o, 0);
    @(negedge clk); rst_n = 1'b1;
    run_cmp("eq_0001", 16'h0001, 16'h0001, 4, 3'b010);
    run_cmp("lt_top", 16'h0400, 16'h8001, 1, 3'b001);
`ifdef SEQ_CMP_SIGNED_EN
    signed_mode = 1'b1;
    run_cmp("signed_gt", 16'h0400, 16'h8001, 1, 3'b100);
    signed_mode = 1'b0;
`endif
    run_cmp("gt_top", 16'hFFFF, 16'h0000, 1, 3'b100);
    run_cmp("lt_mid", 16'h1230, 16'h1240, 3, 3'b001);
    run_cmp("gt_mid", 16'h00F0, 16'h00E0, 3, 3'b100);
    run_cmp("gt_low", 16'hABC5, 16'hABC4, 4, 3'b100);
    @(negedge clk); A = 16'h4000; B = 16'h4001; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1 A = 16'hFFFF; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check("ignore busy", busy, 1);
    check("ignore flags_held", flags_o, prev_f);
    wait_done("ignore", 2, 4, 3'b001);
    @(posedge clk); #1 check("ignore idle", busy, 0);
    @(negedge clk); A = 16'h1234; B = 16'h1234; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b0;
    #1;
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    check("abort flags", flags_o, 0);
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    repeat (6) begin
      @(posedge clk); #1 seen |= int'(done);
    end
    check("abort no_done", seen, 0);
    prev_f = 3'b000;
    run_cmp("eq_after_rst", 16'h4000, 16'h4000, 4, 3'b010);
    @(negedge clk); A = 16'h1000; B = 16'h2000; start = 1'b1;
    @(posedge clk); #1 A = 16'h3000;
    @(posedge clk); #1;
    check("b2b done1", done, 1);
    check("b2b flags1", flags_o, 3'b001);
    @(posedge clk); #1;
    check("b2b busy2", busy, 1);
    @(posedge clk); #1 start = 1'b0;
    check("b2b done2", done, 1);
    check("b2b flags2", flags_o, 3'b100);
    @(posedge clk); #1 check("b2b idle", busy, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/seq_comparator.md
SEQ_COMPARATOR -- requirements
Module: seq_comparator

Interface
- REQ-001 SHALL have parameter WIDTH, default 16: operand width in bits; legal values are multiples of CHUNK, ≥ CHUNK.
- REQ-002 SHALL have parameter CHUNK, default 4: bits compared per cycle; legal range 1..WIDTH.
- REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on rising edge.
- REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
- REQ-005 SHALL have port start, input, 1 bit: request a compare; sampled only in IDLE.
- REQ-006 SHALL have ports A and B, input, WIDTH bits each: operands, captured on the accepted start edge.
- REQ-007 SHALL have port signed_mode, input, 1 bit (present only with SEQ_CMP_SIGNED_EN): 1 means two's-complement compare; sampled with start.
- REQ-008 SHALL have port busy, output, 1 bit: high while a compare is in progress.
- REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse when the result flags update.
- REQ-010 SHALL have ports A_greater_B, A_equal_B and A_less_B, output, 1 bit each: registered result flags, one-hot after the first result.

Function
- REQ-011 SHALL implement FSM states IDLE and CMP; IDLE→CMP on start=1; CMP→IDLE on the deciding edge.
- REQ-012 SHALL, on the accepting edge E0, latch A and B and set chunk index to N−1, where N = WIDTH/CHUNK and chunk N−1 holds the MSBs; busy rises at E0.
- REQ-013 SHALL compare one chunk per cycle, MSB chunk first, decrementing the index.
- REQ-014 SHALL terminate early: the first unequal chunk decides greater/less; if all N chunks are equal, the result is equal.
- REQ-015 SHALL register the flags and pulse done at edge E0+k, where k = (position of the first differing chunk from the top) + 1, or k = N if all are equal. Latency is 1..N cycles.
- REQ-016 SHALL drop busy at the same edge done rises; done is high for exactly one cycle.
- REQ-017 SHALL hold the flags unchanged during busy and after done, until the next result.
- REQ-018 SHALL ignore start while busy; latched operands are unaffected by A/B changes after E0.
- REQ-019 SHALL accept start in the cycle where done is high, since the FSM is in IDLE, giving back-to-back operation.
- REQ-020 SHALL compare chunks unsigned in all modes except as given in REQ-024.

Reset
- REQ-021 SHALL, on rst_n low, immediately force IDLE and busy=0, done=0, and all three flags to 0, with no clock required.
- REQ-022 SHALL, on reset asserted mid-compare, abort the compare with no done pulse; the next start after reset release SHALL behave normally.

Configuration
- REQ-023 SHALL compile the signed-mode feature in only when macro SEQ_CMP_SIGNED_EN is defined.
- REQ-024 SHALL, with SEQ_CMP_SIGNED_EN defined and signed_mode latched as 1, invert the MSB of both operands within the top chunk before comparing; all else is unchanged.
- REQ-025 SHALL, without SEQ_CMP_SIGNED_EN, omit the signed_mode port and perform an unsigned compare only.

Structure
- REQ-026 SHALL place the FSM state enum and the result-flag encoding constants in package seq_comparator_pkg.
- REQ-027 SHALL instantiate one combinational sub-module, chunk_cmp, parameterised by CHUNK, with outputs gt, eq and lt.

Verification (WIDTH=16, CHUNK=4)
- REQ-028 SHALL cover: A=0x0001, B=0x0001, start → done at E0+4, A_equal_B=1, others 0.
- REQ-029 SHALL cover: A=0x0400, B=0x8001, unsigned → done at E0+1, A_less_B=1.
- REQ-030 SHALL cover: with SEQ_CMP_SIGNED_EN, signed_mode=1, A=0x0400, B=0x8001 → done at E0+1, A_greater_B=1.
- REQ-031 SHALL cover: A=0x4000, B=0x4001 → done at E0+4, A_less_B=1. A second start=1 with A=0xFFFF at E0+2 SHALL be ignored.
- REQ-032 SHALL cover: rst_n pulsed low at E0+2 of an equal compare → flags 0, busy 0, no done; then A=0x4000, B=0x4000 → done at E0+4, A_equal_B=1.
- REQ-033 SHALL cover: start held high through done → second compare accepted at the done edge, giving consecutive results with no idle gap.
